// File: rtl/sargantana_hpdc_pkg.sv
// sargantana_hpdc_pkg: shared types and port indices for the HPDC-to-L1.5 request arbiter
// Provides the arbitration mode enum, the port-id type and the default 6-port index map.
package sargantana_hpdc_pkg;
  typedef enum logic {ARB_FIXED_AGING = 1'b0, ARB_ROUND_ROBIN = 1'b1} arb_mode_e;
  localparam int unsigned L15_NUM_PORTS = 6;
  typedef logic [$clog2(L15_NUM_PORTS)-1:0] l15_portid_t;
  localparam l15_portid_t PORT_ICACHE   = 3'd0;
  localparam l15_portid_t PORT_HPDC     = 3'd1;
  localparam l15_portid_t PORT_WBUF     = 3'd2;
  localparam l15_portid_t PORT_UNCACHED = 3'd3;
  localparam l15_portid_t PORT_NC_STORE = 3'd4;
  localparam l15_portid_t PORT_AMO      = 3'd5;
endpackage

// File: rtl/hpdc_l15_port_credit.sv
// hpdc_l15_port_credit: per-port outstanding-credit and starvation-wait counters
// clk_i/rst_i clock and sync active-high reset; req_i valid&enabled request; grant_i port granted;
// rsp_i response addressed to this port; eligible_o may be granted; starving_o wait hit limit;
// busy_o credit nonzero; rsp_err_o response arrived with no credit outstanding.
module hpdc_l15_port_credit #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned StarveLimit = 15,
  parameter bit UseAging = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic grant_i,
  input  logic rsp_i,
  output logic eligible_o,
  output logic starving_o,
  output logic busy_o,
  output logic rsp_err_o
);
  logic [3:0] credit_q;
  logic [7:0] wait_q;
  logic rsp_ok;
  // Eligibility looks only at the registered credit, so a same-cycle response cannot unblock a full port.
  assign eligible_o = req_i & (credit_q < 4'(MaxOutstanding));
  assign starving_o = UseAging & eligible_o & (wait_q == 8'(StarveLimit));
  assign busy_o = credit_q != '0;
  assign rsp_ok = rsp_i & busy_o;
  assign rsp_err_o = rsp_i & ~busy_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q <= '0;
      wait_q <= '0;
    end else begin
      credit_q <= credit_q + 4'(grant_i) - 4'(rsp_ok);
      wait_q <= (!UseAging || !eligible_o || grant_i) ? '0 : (starving_o ? wait_q : wait_q + 8'd1);
    end
  end
  assert property (@(posedge clk_i) disable iff (rst_i) credit_q <= 4'(MaxOutstanding));
endmodule

// File: rtl/hpdc_l15_port_arbiter.sv
// hpdc_l15_port_arbiter: merges N request ports onto the single L1.5 request channel
// clk_i/rst_i clock and sync active-high reset; port_en_i/req_valid_i/req_payload_i per-port request;
// req_ready_o one-hot accept; out_valid_o/out_ready_i/out_payload_o/out_portid_o registered output slot;
// rsp_valid_i/rsp_portid_i credit return; idle_o nothing pending; err_o sticky unexpected response.
module hpdc_l15_port_arbiter #(
  parameter int unsigned NumPorts = 6,
  parameter int unsigned PayloadWidth = 128,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ArbMode = 0,
  parameter int unsigned StarveLimit = 15,
  localparam int unsigned PidW = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumPorts-1:0]              port_en_i,
  input  logic [NumPorts-1:0]              req_valid_i,
  output logic [NumPorts-1:0]              req_ready_o,
  input  logic [NumPorts*PayloadWidth-1:0] req_payload_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [PayloadWidth-1:0]          out_payload_o,
  output logic [PidW-1:0]                  out_portid_o,
  input  logic                             rsp_valid_i,
  input  logic [PidW-1:0]                  rsp_portid_i,
  output logic                             idle_o,
  output logic                             err_o
);
  import sargantana_hpdc_pkg::*;
  localparam bit RoundRobin = (ArbMode == int'(ARB_ROUND_ROBIN));
  logic [NumPorts-1:0] elig, starve, busy, bad, cand, grant;
  logic [PidW-1:0] gid, ptr_q, j;
  logic slot_free;
  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    hpdc_l15_port_credit #(
      .MaxOutstanding(MaxOutstanding),
      .StarveLimit(StarveLimit),
      .UseAging(!RoundRobin)
    ) u_credit (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .req_i(req_valid_i[i] & port_en_i[i]),
      .grant_i(grant[i]),
      .rsp_i(rsp_valid_i && int'(rsp_portid_i) == i),
      .eligible_o(elig[i]),
      .starving_o(starve[i]),
      .busy_o(busy[i]),
      .rsp_err_o(bad[i])
    );
  end
  assign slot_free = !out_valid_o || out_ready_i;
  // Scanning downward leaves the first candidate in search order (lowest index, or nearest to ptr) in gid.
  always_comb begin
    cand = (|starve) ? starve : elig;
    gid = '0;
    j = '0;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      j = RoundRobin ? PidW'((int'(ptr_q) + k) % NumPorts) : PidW'(k);
      if (cand[j]) gid = j;
    end
    grant = (slot_free && !rst_i && |cand) ? NumPorts'(1) << gid : '0;
  end
  assign req_ready_o = grant;
  assign idle_o = !out_valid_o && !(|busy);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_payload_o <= '0;
      out_portid_o <= '0;
      ptr_q <= '0;
      err_o <= 1'b0;
    end else begin
      if (slot_free) out_valid_o <= |grant;
      if (|grant) begin
        out_payload_o <= req_payload_i[int'(gid)*PayloadWidth +: PayloadWidth];
        out_portid_o <= gid;
      end
      if (RoundRobin && |grant) ptr_q <= (int'(gid) == NumPorts - 1) ? '0 : gid + PidW'(1);
      err_o <= err_o | (|bad) | (rsp_valid_i && int'(rsp_portid_i) >= NumPorts);
    end
  end
  assert property (@(posedge clk_i) $onehot0(req_ready_o));
  assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o && !out_ready_i |=> out_valid_o && $stable(out_payload_o) && $stable(out_portid_o));
endmodule

// File: tb/tb_hpdc_l15_port_arbiter.sv
// tb_hpdc_l15_port_arbiter: directed self-checking bench for fixed, aging and round-robin arbiters
module tb_hpdc_l15_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] port_en, req_valid;
  logic [6*128-1:0] payload;
  logic out_ready, rsp_valid;
  logic [2:0] rsp_pid;
  logic [5:0] f_ready, s_ready, r_ready;
  logic f_oval, s_oval, r_oval, f_idle, s_idle, r_idle, f_err, s_err, r_err;
  logic [127:0] f_pay, s_pay, r_pay;
  logic [2:0] f_pid, s_pid, r_pid;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  hpdc_l15_port_arbiter #(.ArbMode(0), .StarveLimit(15)) dut_f (
    .clk_i(clk), .rst_i(rst), .port_en_i(port_en), .req_valid_i(req_valid), .req_ready_o(f_ready),
    .req_payload_i(payload), .out_valid_o(f_oval), .out_ready_i(out_ready), .out_payload_o(f_pay),
    .out_portid_o(f_pid), .rsp_valid_i(rsp_valid), .rsp_portid_i(rsp_pid), .idle_o(f_idle), .err_o(f_err));
  hpdc_l15_port_arbiter #(.ArbMode(0), .StarveLimit(3)) dut_s (
    .clk_i(clk), .rst_i(rst), .port_en_i(port_en), .req_valid_i(req_valid), .req_ready_o(s_ready),
    .req_payload_i(payload), .out_valid_o(s_oval), .out_ready_i(out_ready), .out_payload_o(s_pay),
    .out_portid_o(s_pid), .rsp_valid_i(rsp_valid), .rsp_portid_i(rsp_pid), .idle_o(s_idle), .err_o(s_err));
  hpdc_l15_port_arbiter #(.ArbMode(1)) dut_r (
    .clk_i(clk), .rst_i(rst), .port_en_i(port_en), .req_valid_i(req_valid), .req_ready_o(r_ready),
    .req_payload_i(payload), .out_valid_o(r_oval), .out_ready_i(out_ready), .out_payload_o(r_pay),
    .out_portid_o(r_pid), .rsp_valid_i(rsp_valid), .rsp_portid_i(rsp_pid), .idle_o(r_idle), .err_o(r_err));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    port_en = '1;
    req_valid = '0;
    out_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_pid = '0;
    for (int i = 0; i < 6; i++) payload[i*128 +: 128] = 128'(32'h10 + i);
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req_valid = '1;
    tick();
    #1;
    n_chk++; if (f_ready !== 6'b0) begin n_fail++; $display("FAIL reset_ready got %b want 000000", f_ready); end
    n_chk++; if (f_oval !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", f_oval); end
    n_chk++; if (f_pay !== 128'h0) begin n_fail++; $display("FAIL reset_payload got %h want 0", f_pay); end
    n_chk++; if (f_pid !== 3'd0) begin n_fail++; $display("FAIL reset_portid got %0d want 0", f_pid); end
    n_chk++; if (f_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", f_idle); end
    n_chk++; if (f_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", f_err); end
    n_chk++; if (r_ready !== 6'b0 || r_oval !== 1'b0) begin n_fail++; $display("FAIL reset_rr got ready %b valid %b want 000000/0", r_ready, r_oval); end
  endtask
  task automatic test_fixed_priority;
    int seq [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 4};
    do_reset();
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      #1;
      n_chk++; if (f_ready !== 6'(1 << seq[c])) begin n_fail++; $display("FAIL fixed_ready[%0d] got %b want port %0d", c, f_ready, seq[c]); end
      tick();
      n_chk++; if (f_oval !== 1'b1 || f_pid !== 3'(seq[c]) || f_pay !== 128'(32'h10 + seq[c])) begin
        n_fail++; $display("FAIL fixed_out[%0d] got v%b id%0d pay%h want v1 id%0d", c, f_oval, f_pid, f_pay, seq[c]);
      end
    end
    n_chk++; if (f_idle !== 1'b0) begin n_fail++; $display("FAIL fixed_idle got %b want 0", f_idle); end
  endtask
  task automatic test_starvation;
    int seq [8] = '{0, 0, 0, 5, 0, 0, 0, 5};
    do_reset();
    req_valid = 6'b100001;
    for (int c = 0; c < 8; c++) begin
      rsp_valid = (c > 0) && (seq[c > 0 ? c - 1 : 0] == 0);
      rsp_pid = 3'd0;
      #1;
      n_chk++; if (s_ready !== 6'(1 << seq[c])) begin n_fail++; $display("FAIL starve_ready[%0d] got %b want port %0d", c, s_ready, seq[c]); end
      tick();
      n_chk++; if (s_pid !== 3'(seq[c])) begin n_fail++; $display("FAIL starve_portid[%0d] got %0d want %0d", c, s_pid, seq[c]); end
    end
    rsp_valid = 1'b0;
    n_chk++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL starve_err got %b want 0", s_err); end
  endtask
  task automatic test_round_robin;
    int seq [6] = '{1, 3, 5, 1, 3, 5};
    do_reset();
    req_valid = 6'b101010;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_chk++; if (r_ready !== 6'(1 << seq[c])) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want port %0d", c, r_ready, seq[c]); end
      tick();
      n_chk++; if (r_pid !== 3'(seq[c]) || r_pay !== 128'(32'h10 + seq[c])) begin
        n_fail++; $display("FAIL rr_out[%0d] got id%0d pay%h want id%0d", c, r_pid, r_pay, seq[c]);
      end
    end
  endtask
  task automatic test_stall;
    do_reset();
    req_valid = 6'b000100;
    payload[2*128 +: 128] = 128'hA5;
    #1;
    n_chk++; if (f_ready !== 6'b000100) begin n_fail++; $display("FAIL stall_first_ready got %b want 000100", f_ready); end
    tick();
    out_ready = 1'b0;
    payload[2*128 +: 128] = 128'h5A;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++; if (f_ready !== 6'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 000000", c, f_ready); end
      n_chk++; if (f_oval !== 1'b1 || f_pay !== 128'hA5 || f_pid !== 3'd2) begin
        n_fail++; $display("FAIL stall_hold[%0d] got v%b pay%h id%0d want v1 pay a5 id2", c, f_oval, f_pay, f_pid);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (f_ready !== 6'b000100) begin n_fail++; $display("FAIL stall_release_ready got %b want 000100", f_ready); end
    tick();
    n_chk++; if (f_pay !== 128'h5A || f_pid !== 3'd2) begin n_fail++; $display("FAIL stall_release_out got pay%h id%0d want 5a/2", f_pay, f_pid); end
  endtask
  task automatic test_credit;
    do_reset();
    req_valid = 6'b000100;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++; if (f_ready !== 6'b000100) begin n_fail++; $display("FAIL credit_fill[%0d] got %b want 000100", c, f_ready); end
      tick();
    end
    rsp_valid = 1'b1;
    rsp_pid = 3'd2;
    #1;
    n_chk++; if (f_ready !== 6'b0) begin n_fail++; $display("FAIL credit_full_rsp got %b want 000000", f_ready); end
    tick();
    rsp_valid = 1'b0;
    #1;
    n_chk++; if (f_ready !== 6'b000100) begin n_fail++; $display("FAIL credit_after_rsp got %b want 000100", f_ready); end
    tick();
    #1;
    n_chk++; if (f_ready !== 6'b0) begin n_fail++; $display("FAIL credit_refull got %b want 000000", f_ready); end
    req_valid = '0;
    rsp_valid = 1'b1;
    tick();
    tick();
    req_valid = 6'b000100;
    #1;
    n_chk++; if (f_ready !== 6'b000100) begin n_fail++; $display("FAIL credit_grant_rsp got %b want 000100", f_ready); end
    tick();
    rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (f_ready !== (c < 2 ? 6'b000100 : 6'b0)) begin n_fail++; $display("FAIL credit_from2[%0d] got %b", c, f_ready); end
      tick();
    end
    req_valid = '0;
    rsp_valid = 1'b1;
    repeat (4) tick();
    rsp_valid = 1'b0;
    #1;
    n_chk++; if (f_idle !== 1'b1 || f_err !== 1'b0) begin n_fail++; $display("FAIL credit_drain got idle%b err%b want idle1 err0", f_idle, f_err); end
  endtask
  task automatic test_err_reset;
    do_reset();
    rsp_valid = 1'b1;
    rsp_pid = 3'd4;
    tick();
    rsp_valid = 1'b0;
    n_chk++; if (f_err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", f_err); end
    req_valid = '1;
    tick();
    tick();
    n_chk++; if (f_err !== 1'b1 || f_idle !== 1'b0) begin n_fail++; $display("FAIL err_sticky got err%b idle%b want err1 idle0", f_err, f_idle); end
    rst = 1'b1;
    #1;
    n_chk++; if (f_ready !== 6'b0) begin n_fail++; $display("FAIL rst_ready got %b want 000000", f_ready); end
    tick();
    rst = 1'b0;
    n_chk++; if (f_oval !== 1'b0 || f_pay !== 128'h0 || f_pid !== 3'd0) begin
      n_fail++; $display("FAIL rst_out got v%b pay%h id%0d want 0/0/0", f_oval, f_pay, f_pid);
    end
    n_chk++; if (f_idle !== 1'b1 || f_err !== 1'b0) begin n_fail++; $display("FAIL rst_state got idle%b err%b want idle1 err0", f_idle, f_err); end
    #1;
    n_chk++; if (f_ready !== 6'b000001) begin n_fail++; $display("FAIL rst_resume got %b want 000001", f_ready); end
    tick();
    req_valid = '0;
    rsp_valid = 1'b1;
    rsp_pid = 3'd6;
    tick();
    rsp_valid = 1'b0;
    n_chk++; if (f_err !== 1'b1) begin n_fail++; $display("FAIL err_badid got %b want 1", f_err); end
  endtask
  initial begin
    do_reset();
    test_reset();
    test_fixed_priority();
    test_starvation();
    test_round_robin();
    test_stall();
    test_credit();
    test_err_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
